// File: rtl/spi_param_bridge.sv
// SPI word command decoder: header (op/addr) then auto-incrementing parameter writes or reads.
// Optional SPI_BRIDGE_WR_ECHO_EN: echo each written word back on the transmit load path.
module spi_param_bridge #(
  parameter int PARAM_WIDTH = 40,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   ssel_i,
  input  logic                   rx_valid_i,
  input  logic [PARAM_WIDTH-1:0] rx_word_i,
  output logic                   tx_load_o,
  output logic [PARAM_WIDTH-1:0] tx_word_o,
  output logic                   rd_en_o,
  output logic [ADDR_WIDTH-1:0]  rd_addr_o,
  input  logic [PARAM_WIDTH-1:0] rd_data_i,
  output logic                   wr_en_o,
  output logic [ADDR_WIDTH-1:0]  wr_addr_o,
  output logic [PARAM_WIDTH-1:0] wr_data_o,
  output logic                   err_opcode_o,
  output logic                   err_overrun_o
);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    rd_wait_q;
  logic                    ssel_q;
  logic                    tx_load_q;
  logic [PARAM_WIDTH-1:0]  tx_word_q;
  logic                    rd_en_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [PARAM_WIDTH-1:0]  wr_data_q;
  logic                    err_opcode_q;
  logic                    err_overrun_q;

  logic [1:0]              op_d;
  logic [ADDR_WIDTH-1:0]   hdr_addr_d;
  logic [ADDR_WIDTH-1:0]   ptr_inc_d;
  logic                    rd_busy_d;

  always_comb begin
    op_d       = rx_word_i[PARAM_WIDTH-1 -: 2];
    hdr_addr_d = rx_word_i[ADDR_WIDTH-1:0];
    ptr_inc_d  = ptr_q + ADDR_ONE;
    rd_busy_d  = rd_en_q | rd_wait_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      rd_wait_q     <= 1'b0;
      ssel_q        <= 1'b0;
      tx_load_q     <= 1'b0;
      tx_word_q     <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      err_opcode_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      ssel_q    <= ssel_i;
      // Read pipeline: strobe at T+1, data captured at T+2, presented at T+3.
      rd_wait_q <= rd_en_q & ~ssel_i;
      if (rd_wait_q && !ssel_i) begin
        tx_load_q <= 1'b1;
        tx_word_q <= rd_data_i;
      end
      if (ssel_q && !ssel_i) begin
        err_opcode_q  <= 1'b0;
        err_overrun_q <= 1'b0;
      end
      if (ssel_i) begin
        state_q <= IDLE;
      end else if (rx_valid_i) begin
        if (rd_busy_d) begin
          err_overrun_q <= 1'b1;
        end else begin
          case (state_q)
            IDLE: begin
              case (op_d)
                2'b01: begin
                  ptr_q   <= hdr_addr_d;
                  state_q <= WR;
                end
                2'b10: begin
                  ptr_q     <= hdr_addr_d;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= hdr_addr_d;
                  state_q   <= RD;
                end
                2'b00: state_q <= DRAIN;
                2'b11: begin
                  err_opcode_q <= 1'b1;
                  state_q      <= DRAIN;
                end
              endcase
            end
            WR: begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ptr_q;
              wr_data_q <= rx_word_i;
              ptr_q     <= ptr_inc_d;
`ifdef SPI_BRIDGE_WR_ECHO_EN
              tx_load_q <= 1'b1;
              tx_word_q <= rx_word_i;
`endif
            end
            RD: begin
              ptr_q     <= ptr_inc_d;
              rd_en_q   <= 1'b1;
              rd_addr_q <= ptr_inc_d;
            end
            DRAIN: ;
          endcase
        end
      end
    end
  end

  assign tx_load_o     = tx_load_q;
  assign tx_word_o     = tx_word_q;
  assign rd_en_o       = rd_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign err_opcode_o  = err_opcode_q;
  assign err_overrun_o = err_overrun_q;

endmodule
